// File: rtl/lenet_xil_pkg.sv
// Shared types and constants for the LeNet5 Xillybus mem_8 configuration bank.
package lenet_xil_pkg;

  localparam int MEM8_DEPTH      = 32;
  localparam int MEM8_AW         = 5;
  localparam int DEF_COMMIT_ADDR = 27;
  localparam int DEF_STATUS_BASE = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_COPY,
    ST_START
  } state_e;

endpackage

// File: rtl/mem8_byte_bank.sv
// Byte-wide register bank: one registered write port, one combinational read
// port and a flat view of all bytes (byte i at bits [8i+7:8i]).
module mem8_byte_bank
  import lenet_xil_pkg::*;
#(
  parameter int NBYTES = DEF_COMMIT_ADDR
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [MEM8_AW-1:0]    waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [MEM8_AW-1:0]    raddr_i,
  output logic [7:0]            rdata_o,
  output logic [8*NBYTES-1:0]   flat_o
);

  logic [8*NBYTES-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (waddr_i == MEM8_AW'(i)) mem_q[8*i +: 8] <= wdata_i;
      end
    end
  end

  // Addresses at or beyond NBYTES read as zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (raddr_i == MEM8_AW'(i)) rdata_o = mem_q[8*i +: 8];
    end
  end

  assign flat_o = mem_q;

endmodule

// File: rtl/lenet_mem8_cfg_bank.sv
// Xillybus mem_8 responder holding the LeNet5 run configuration, status window
// and commit doorbell. Optional double buffering: LENET_MEM8_SHADOW_EN.
module lenet_mem8_cfg_bank
  import lenet_xil_pkg::*;
#(
  parameter int COMMIT_ADDR = DEF_COMMIT_ADDR,
  parameter int STATUS_BASE = DEF_STATUS_BASE
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst_n,
  input  logic                     user_r_mem_8_rden,
  output logic [7:0]               user_r_mem_8_data,
  output logic                     user_r_mem_8_empty,
  output logic                     user_r_mem_8_eof,
  input  logic                     user_r_mem_8_open,
  input  logic                     user_w_mem_8_wren,
  input  logic [7:0]               user_w_mem_8_data,
  output logic                     user_w_mem_8_full,
  input  logic                     user_w_mem_8_open,
  input  logic [MEM8_AW-1:0]       user_mem_8_addr,
  input  logic                     user_mem_8_addr_update,
  input  logic [31:0]              status_in,
  input  logic                     busy,
  output logic [8*COMMIT_ADDR-1:0] cfg_q,
  output logic                     start_pulse,
  output state_e                   dbg_state_o
);

  // Handshake: the host asserts rden/wren only while empty/full are low; a
  // strobe seen while its flag is high is dropped and does not move ptr.
  state_e               state_q;
  logic                 pending_q;
  logic                 start_q;
  logic [7:0]           data_q;
  logic [MEM8_AW-1:0]   ptr_q, ptr_d;
  logic [MEM8_AW-1:0]   eff_addr;
  logic                 rd_fire, wr_fire, commit_set;
  logic [7:0]           bank_rdata, rd_byte;

  assign eff_addr   = user_mem_8_addr_update ? user_mem_8_addr : ptr_q;
  assign rd_fire    = user_r_mem_8_rden & ~user_r_mem_8_empty;
  assign wr_fire    = user_w_mem_8_wren & ~user_w_mem_8_full;
  assign commit_set = wr_fire && (eff_addr == MEM8_AW'(COMMIT_ADDR)) && user_w_mem_8_data[0];
  assign ptr_d      = eff_addr + MEM8_AW'(rd_fire | wr_fire);

`ifdef LENET_MEM8_SHADOW_EN
  logic [MEM8_AW-1:0]       copy_idx_q;
  logic [7:0]               active_rdata;
  logic [8*COMMIT_ADDR-1:0] shadow_flat;

  // The shadow read port is borrowed by COPY; host reads are blocked then.
  mem8_byte_bank #(.NBYTES(COMMIT_ADDR)) u_shadow (
    .clk_i(bus_clk), .rst_ni(bus_rst_n),
    .we_i(wr_fire && (eff_addr < MEM8_AW'(COMMIT_ADDR))),
    .waddr_i(eff_addr), .wdata_i(user_w_mem_8_data),
    .raddr_i((state_q == ST_COPY) ? copy_idx_q : eff_addr),
    .rdata_o(bank_rdata), .flat_o(shadow_flat)
  );

  mem8_byte_bank #(.NBYTES(COMMIT_ADDR)) u_active (
    .clk_i(bus_clk), .rst_ni(bus_rst_n),
    .we_i(state_q == ST_COPY),
    .waddr_i(copy_idx_q), .wdata_i(bank_rdata),
    .raddr_i(copy_idx_q),
    .rdata_o(active_rdata), .flat_o(cfg_q)
  );

  assign user_w_mem_8_full  = (state_q == ST_WAIT_IDLE) || (state_q == ST_COPY);
  assign user_r_mem_8_empty = (state_q == ST_WAIT_IDLE) || (state_q == ST_COPY);
`else
  mem8_byte_bank #(.NBYTES(COMMIT_ADDR)) u_bank (
    .clk_i(bus_clk), .rst_ni(bus_rst_n),
    .we_i(wr_fire && (eff_addr < MEM8_AW'(COMMIT_ADDR))),
    .waddr_i(eff_addr), .wdata_i(user_w_mem_8_data),
    .raddr_i(eff_addr),
    .rdata_o(bank_rdata), .flat_o(cfg_q)
  );

  assign user_w_mem_8_full  = 1'b0;
  assign user_r_mem_8_empty = 1'b0;
`endif

  always_comb begin
    rd_byte = '0;
    if (eff_addr < MEM8_AW'(COMMIT_ADDR)) begin
      rd_byte = bank_rdata;
    end else if (eff_addr == MEM8_AW'(COMMIT_ADDR)) begin
      rd_byte = {6'b0, busy, pending_q};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (eff_addr == MEM8_AW'(STATUS_BASE + k)) rd_byte = status_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      data_q <= '0;
      ptr_q  <= '0;
    end else begin
      if (rd_fire) data_q <= rd_byte;
      if (!user_r_mem_8_open && !user_w_mem_8_open) ptr_q <= '0;
      else                                          ptr_q <= ptr_d;
    end
  end

  // A fresh commit landing in the START cycle survives the clear and re-arms.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      start_q    <= 1'b0;
`ifdef LENET_MEM8_SHADOW_EN
      copy_idx_q <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (pending_q) state_q <= ST_WAIT_IDLE;
        ST_WAIT_IDLE: begin
          if (!busy) begin
`ifdef LENET_MEM8_SHADOW_EN
            state_q    <= ST_COPY;
            copy_idx_q <= '0;
`else
            state_q <= ST_START;
            start_q <= 1'b1;
`endif
          end
        end
`ifdef LENET_MEM8_SHADOW_EN
        ST_COPY: begin
          copy_idx_q <= copy_idx_q + 1'b1;
          if (copy_idx_q == MEM8_AW'(COMMIT_ADDR - 1)) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end
        end
`endif
        ST_START: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      if (commit_set)               pending_q <= 1'b1;
      else if (state_q == ST_START) pending_q <= 1'b0;
    end
  end

  assign user_r_mem_8_data = data_q;
  assign user_r_mem_8_eof  = 1'b0;
  assign start_pulse       = start_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_lenet_mem8_cfg_bank.sv
// Directed self-checking bench for lenet_mem8_cfg_bank (either build of
// LENET_MEM8_SHADOW_EN).
module tb_lenet_mem8_cfg_bank;
  import lenet_xil_pkg::*;

  localparam int NCFG = DEF_COMMIT_ADDR;
`ifdef LENET_MEM8_SHADOW_EN
  localparam bit SHADOW = 1'b1;
  localparam int LAT    = 2 + NCFG;
`else
  localparam bit SHADOW = 1'b0;
  localparam int LAT    = 2;
`endif

  logic              bus_clk = 1'b0;
  logic              bus_rst_n = 1'b0;
  logic              user_r_mem_8_rden = 1'b0;
  logic [7:0]        user_r_mem_8_data;
  logic              user_r_mem_8_empty;
  logic              user_r_mem_8_eof;
  logic              user_r_mem_8_open = 1'b1;
  logic              user_w_mem_8_wren = 1'b0;
  logic [7:0]        user_w_mem_8_data = '0;
  logic              user_w_mem_8_full;
  logic              user_w_mem_8_open = 1'b1;
  logic [4:0]        user_mem_8_addr = '0;
  logic              user_mem_8_addr_update = 1'b0;
  logic [31:0]       status_in = '0;
  logic              busy = 1'b0;
  logic [8*NCFG-1:0] cfg_q;
  logic              start_pulse;
  state_e            dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8*NCFG-1:0] exp_host = '0;
  logic [8*NCFG-1:0] exp_act  = '0;

  lenet_mem8_cfg_bank dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_r_mem_8_rden(user_r_mem_8_rden), .user_r_mem_8_data(user_r_mem_8_data),
    .user_r_mem_8_empty(user_r_mem_8_empty), .user_r_mem_8_eof(user_r_mem_8_eof),
    .user_r_mem_8_open(user_r_mem_8_open),
    .user_w_mem_8_wren(user_w_mem_8_wren), .user_w_mem_8_data(user_w_mem_8_data),
    .user_w_mem_8_full(user_w_mem_8_full), .user_w_mem_8_open(user_w_mem_8_open),
    .user_mem_8_addr(user_mem_8_addr), .user_mem_8_addr_update(user_mem_8_addr_update),
    .status_in(status_in), .busy(busy), .cfg_q(cfg_q), .start_pulse(start_pulse),
    .dbg_state_o(dbg_state_o)
  );

  always #5 bus_clk = ~bus_clk;

  // Drivers: inputs change on the falling edge, outputs are read there too.
  task automatic seek(input logic [4:0] a);
    user_mem_8_addr = a;
    user_mem_8_addr_update = 1'b1;
    @(negedge bus_clk);
    user_mem_8_addr_update = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    user_w_mem_8_data = d;
    user_w_mem_8_wren = 1'b1;
    @(negedge bus_clk);
    user_w_mem_8_wren = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d);
    user_r_mem_8_rden = 1'b1;
    @(negedge bus_clk);
    user_r_mem_8_rden = 1'b0;
    d = user_r_mem_8_data;
  endtask

  task automatic model_wr(input int idx, input logic [7:0] d);
    exp_host[8*idx +: 8] = d;
    if (!SHADOW) exp_act[8*idx +: 8] = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge bus_clk);
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
    n_checks++; if (user_r_mem_8_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", user_r_mem_8_data); end
    n_checks++; if ({user_r_mem_8_empty, user_r_mem_8_eof, user_w_mem_8_full} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {user_r_mem_8_empty, user_r_mem_8_eof, user_w_mem_8_full}); end
    n_checks++; if (cfg_q !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h expected 0", cfg_q); end
    n_checks++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", start_pulse); end
    n_checks++; if (dbg_state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, ST_IDLE); end
  endtask

  task automatic test_write_read();
    logic [7:0] b;
    logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
    seek(5'd0);
    for (int i = 0; i < 3; i++) begin wr(exp_b[i]); model_wr(i, exp_b[i]); end
    seek(5'd0);
    for (int i = 0; i < 3; i++) begin
      rd(b);
      n_checks++; if (b !== exp_b[i]) begin n_fail++; $display("FAIL rd_byte%0d: got %h expected %h", i, b, exp_b[i]); end
    end
    rd(b);  // ptr should be 3: unwritten byte reads zero
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL rd_ptr3: got %h expected 00", b); end
    n_checks++; if (cfg_q !== exp_act) begin n_fail++; $display("FAIL cfg_after_wr: got %h expected %h", cfg_q, exp_act); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    seek(5'd30);
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i));
    model_wr(0, 8'hA2);
    model_wr(1, 8'hA3);
    seek(5'd0);
    rd(b);
    n_checks++; if (b !== 8'hA2) begin n_fail++; $display("FAIL wrap_b0: got %h expected a2", b); end
    rd(b);
    n_checks++; if (b !== 8'hA3) begin n_fail++; $display("FAIL wrap_b1: got %h expected a3", b); end
    seek(5'd30);
    rd(b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL status_wprot30: got %h expected 00", b); end
  endtask

  task automatic test_status();
    logic [7:0] b;
    logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    status_in = 32'hDEADBEEF;
    seek(5'd28);
    for (int i = 0; i < 4; i++) begin
      rd(b);
      n_checks++; if (b !== exp_b[i]) begin n_fail++; $display("FAIL status_b%0d: got %h expected %h", i, b, exp_b[i]); end
    end
    rd(b);  // ptr wrapped 31 -> 0
    n_checks++; if (b !== 8'hA2) begin n_fail++; $display("FAIL read_wrap: got %h expected a2", b); end
  endtask

  task automatic test_rw_same_cycle();
    logic [7:0] b;
    seek(5'd2);
    user_w_mem_8_data = 8'h77;
    user_w_mem_8_wren = 1'b1;
    user_r_mem_8_rden = 1'b1;
    @(negedge bus_clk);
    user_w_mem_8_wren = 1'b0;
    user_r_mem_8_rden = 1'b0;
    model_wr(2, 8'h77);
    n_checks++; if (user_r_mem_8_data !== 8'h33) begin n_fail++; $display("FAIL rw_old_byte: got %h expected 33", user_r_mem_8_data); end
    rd(b);  // ptr advanced by one only
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL rw_ptr_step: got %h expected 00", b); end
    seek(5'd2);
    rd(b);
    n_checks++; if (b !== 8'h77) begin n_fail++; $display("FAIL rw_new_byte: got %h expected 77", b); end
  endtask

  task automatic test_commit();
    logic [7:0] b;
    int pulses = 0;
    seek(5'd27);
    wr(8'h01);  // now one half-cycle after edge N
    for (int c = 0; c <= LAT + 4; c++) begin
      n_checks++; if (start_pulse !== (c == LAT)) begin n_fail++; $display("FAIL commit_pulse_c%0d: got %b expected %b", c, start_pulse, (c == LAT)); end
      n_checks++; if (user_w_mem_8_full !== (SHADOW && c >= 1 && c < LAT)) begin n_fail++; $display("FAIL commit_full_c%0d: got %b expected %b", c, user_w_mem_8_full, (SHADOW && c >= 1 && c < LAT)); end
      if (c == LAT) begin
        exp_act = exp_host;
        n_checks++; if (cfg_q !== exp_act) begin n_fail++; $display("FAIL commit_cfg: got %h expected %h", cfg_q, exp_act); end
      end
      if (start_pulse === 1'b1) pulses++;
      @(negedge bus_clk);
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL commit_npulse: got %0d expected 1", pulses); end
    seek(5'd27);
    rd(b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL commit_clear: got %h expected 00", b); end
  endtask

  task automatic test_back_to_back_commit();
    logic [7:0] b;
    int pulses = 0;
    busy = 1'b1;
    seek(5'd27);
    wr(8'h01);
    repeat (3) @(negedge bus_clk);
`ifndef LENET_MEM8_SHADOW_EN
    seek(5'd27);
    wr(8'h01);
    seek(5'd27);
    rd(b);
    n_checks++; if (b !== 8'h03) begin n_fail++; $display("FAIL deferred_status: got %h expected 03", b); end
`endif
    n_checks++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL deferred_pulse: got %b expected 0", start_pulse); end
    busy = 1'b0;
    for (int c = 0; c < LAT + 10; c++) begin
      if (start_pulse === 1'b1) pulses++;
      @(negedge bus_clk);
    end
    exp_act = exp_host;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL coalesce_npulse: got %0d expected 1", pulses); end
    seek(5'd27);
    rd(b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL coalesce_clear: got %h expected 00", b); end
  endtask

  task automatic test_seek_rden_and_close();
    logic [7:0] b;
    seek(5'd5);
    wr(8'h55); model_wr(5, 8'h55);
    wr(8'h66); model_wr(6, 8'h66);
    user_mem_8_addr = 5'd5;
    user_mem_8_addr_update = 1'b1;
    user_r_mem_8_rden = 1'b1;
    @(negedge bus_clk);
    user_mem_8_addr_update = 1'b0;
    user_r_mem_8_rden = 1'b0;
    n_checks++; if (user_r_mem_8_data !== 8'h55) begin n_fail++; $display("FAIL seek_rden: got %h expected 55", user_r_mem_8_data); end
    rd(b);
    n_checks++; if (b !== 8'h66) begin n_fail++; $display("FAIL seek_rden_ptr6: got %h expected 66", b); end
    user_r_mem_8_open = 1'b0;
    user_w_mem_8_open = 1'b0;
    @(negedge bus_clk);
    user_r_mem_8_open = 1'b1;
    user_w_mem_8_open = 1'b1;
    rd(b);
    n_checks++; if (b !== exp_host[7:0]) begin n_fail++; $display("FAIL close_ptr0: got %h expected %h", b, exp_host[7:0]); end
  endtask

  task automatic test_reset_mid_commit();
    logic [7:0] b;
    int pulses = 0;
    seek(5'd27);
    wr(8'h01);
    @(negedge bus_clk);
    #2 bus_rst_n = 1'b0;
    #1;
    n_checks++; if (dbg_state_o !== ST_IDLE) begin n_fail++; $display("FAIL arst_state: got %0d expected %0d", dbg_state_o, ST_IDLE); end
    n_checks++; if (cfg_q !== '0) begin n_fail++; $display("FAIL arst_cfg: got %h expected 0", cfg_q); end
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    exp_host = '0;
    exp_act  = '0;
    for (int c = 0; c < LAT + 10; c++) begin
      if (start_pulse === 1'b1) pulses++;
      @(negedge bus_clk);
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL arst_npulse: got %0d expected 0", pulses); end
    seek(5'd27);
    rd(b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL arst_pending: got %h expected 00", b); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_status();
    test_rw_same_cycle();
    test_commit();
    test_back_to_back_commit();
    test_seek_rden_and_close();
    test_reset_mid_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
